// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU pipeline.
// Holds the default lane geometry and the operation-code enumeration used by
// both the per-lane ALU and the pipeline top level.
package vec_alu_pkg;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_MIN = 4'd8,
    OP_MAX = 4'd9,
    OP_SLT = 4'd10
  } op_e;

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational single-lane ALU.
// Ports:
//   a, b  : lane operands (LANE_W bits)
//   op    : operation code; codes outside the enum produce 0
//   y     : lane result, modulo 2^LANE_W
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  op_e               op,
  output logic [LANE_W-1:0] y
);

  localparam int SH_W = $clog2(LANE_W);

  logic [SH_W-1:0]          sh;
  logic signed [LANE_W-1:0] sa;
  logic signed [LANE_W-1:0] sb;
  logic                     lt;

  // Shift amount comes only from the low bits of this lane's b.
  assign sh = b[SH_W-1:0];
  assign sa = a;
  assign sb = b;
  assign lt = sa < sb;

  // NOTE: y gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SLL: y = a << sh;
      OP_SRL: y = a >> sh;
      OP_SRA: y = sa >>> sh;
      OP_MIN: y = lt ? a : b;
      OP_MAX: y = lt ? b : a;
      OP_SLT: y = {{(LANE_W-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage pipelined vector ALU with valid/ready handshakes on both sides.
// S1 registers the accepted operands, op, mode and mask; S2 registers the
// masked/forced lane results and their zero flags.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake
//   a, b                : operands, lane i at [i*LANE_W +: LANE_W]
//   op                  : operation code (vec_alu_pkg::op_e)
//   vectorial           : 1 = all lanes, 0 = lane 0 only, upper lanes forced 0
//   lane_mask           : per-lane enable in vector mode (disabled lanes pass a)
//   out_valid, out_ready: output handshake
//   result              : lane results
//   zero, lane_zero     : lane-0 and per-lane result==0 flags
module vector_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  localparam int W     = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [3:0]       op,
  input  logic             vectorial,
  input  logic [LANES-1:0] lane_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             zero,
  output logic [LANES-1:0] lane_zero
);

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  op_e              s1_op;
  logic             s1_vec;
  logic [LANES-1:0] s1_mask;

  logic             s2_adv;
  logic             s1_adv;
  logic [W-1:0]     alu_y;
  logic [W-1:0]     next_result;
  logic [LANES-1:0] next_zero;

  // A stage advances when it is empty or its downstream stage advances.
  // in_ready depends only on state and out_ready, never on in_valid; it is
  // gated by rst_n so the block refuses input while held in reset.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rst_n && s1_adv;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_alu_lane #(.LANE_W(LANE_W)) u_lane (
      .a  (s1_a[g*LANE_W +: LANE_W]),
      .b  (s1_b[g*LANE_W +: LANE_W]),
      .op (s1_op),
      .y  (alu_y[g*LANE_W +: LANE_W])
    );
  end

  // Lane selection: masked-off vector lanes pass a through; scalar mode keeps
  // only lane 0 and forces the rest to zero. Zero flags follow the final value.
  always_comb begin
    next_result = '0;
    next_zero   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_vec) begin
        next_result[i*LANE_W +: LANE_W] = s1_mask[i] ? alu_y[i*LANE_W +: LANE_W]
                                                     : s1_a[i*LANE_W +: LANE_W];
      end else if (i == 0) begin
        next_result[i*LANE_W +: LANE_W] = alu_y[i*LANE_W +: LANE_W];
      end
      next_zero[i] = (next_result[i*LANE_W +: LANE_W] == '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; this is what lets S1->S2 shift and S1 reload coexist in
  // one edge.
  // NOTE: the datapath registers are reset along with the valid bits so the
  // outputs read as zero during and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_vec   <= 1'b0;
      s1_mask  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_op   <= op_e'(op);
        s1_vec  <= vectorial;
        s1_mask <= lane_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      lane_zero <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result    <= next_result;
        lane_zero <= next_zero;
      end
    end
  end

  assign zero = lane_zero[0];

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe (LANES=4, LANE_W=32).
// Stimulus pushes expected results into a queue; a monitor on the falling
// edge pops and compares whenever an output transfer is about to happen.
module tb_vector_alu_pipe;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int W      = LANES * LANE_W;

  typedef struct packed {
    logic [W-1:0]     r;
    logic [LANES-1:0] z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [3:0]       op = '0;
  logic             vectorial = 1'b0;
  logic [LANES-1:0] lane_mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     result;
  logic             zero;
  logic [LANES-1:0] lane_zero;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   run_len = 0;
  int   max_run = 0;
  logic held_ok = 1'b0;
  logic [W-1:0]     held_r;
  logic [LANES-1:0] held_z;

  always #5 clk = ~clk;

  vector_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .vectorial (vectorial),
    .lane_mask (lane_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .lane_zero (lane_zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [LANE_W-1:0] x);
    return {LANES{x}};
  endfunction

  // Reference lane operation for the random phase.
  function automatic logic [LANE_W-1:0] ref_lane(input logic [LANE_W-1:0] x,
                                                 input logic [LANE_W-1:0] y,
                                                 input logic [3:0] o);
    int sh;
    longint sx, sy;
    sh = int'(y % LANE_W);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return x << sh;
      4'd6:  return x >> sh;
      4'd7:  return LANE_W'(sx >>> sh);
      4'd8:  return (sx < sy) ? x : y;
      4'd9:  return (sx > sy) ? x : y;
      4'd10: return (sx < sy) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [3:0] o, input logic v,
                                  input logic [LANES-1:0] m);
    exp_t e;
    logic [LANE_W-1:0] lv;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!v && i != 0)   lv = '0;
      else if (v && !m[i]) lv = x[i*LANE_W +: LANE_W];
      else                lv = ref_lane(x[i*LANE_W +: LANE_W], y[i*LANE_W +: LANE_W], o);
      e.r[i*LANE_W +: LANE_W] = lv;
      e.z[i] = (lv == '0);
    end
    return e;
  endfunction

  // Present one operation (called at posedge+1), wait for acceptance, push
  // its expected response, and return at posedge+1 after the accepting edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [3:0] xo, input logic xv,
                       input logic [LANES-1:0] xm,
                       input logic [W-1:0] er, input logic [LANES-1:0] ez);
    logic acc;
    int   n;
    exp_t e;
    a = xa; b = xb; op = xo; vectorial = xv; lane_mask = xm; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    else begin
      e.r = er;
      e.z = ez;
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
    // Junk on the data inputs while idle must be ignored.
    a = {4{$urandom()}}; b = {4{$urandom()}}; op = 4'($urandom()); lane_mask = 4'($urandom());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", W'(exp_q.size()), 0);
  endtask

  // Monitor: compares on output transfers and checks hold stability on stalls.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && held_ok) begin
      check("hold_valid", W'(out_valid), 1);
      check("hold_result", result, held_r);
      check("hold_lane_zero", W'(lane_zero), W'(held_z));
    end
    held_ok = rst_n && out_valid && !out_ready;
    held_r  = result;
    held_z  = lane_zero;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", W'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.r);
        check("lane_zero", W'(lane_zero), W'(e.z));
        check("zero", W'(zero), W'(e.z[0]));
      end
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  initial begin
    int   idx, cyc, first_low, stale;
    logic acc;
    exp_t e;
    logic [W-1:0] ra, rb;
    logic [3:0]   ro;
    logic         rv;
    logic [LANES-1:0] rm;

    // Reset state
    #2;
    check("rst_in_ready", W'(in_ready), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_lane_zero", W'(lane_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", W'(in_ready), 1);
    out_ready = 1'b1;

    // Lane isolation with latency measurement
    issue(rep(32'hFFFF_FFFF), rep(32'd1), 4'd0, 1'b1, 4'hF, '0, 4'hF);
    check("latency_cycle1", W'(out_valid), 0);
    @(posedge clk);
    #1;
    check("latency_cycle2", W'(out_valid), 1);
    drain();

    // Per-lane sra with mask 0101
    issue(rep(32'h8000_0000), {32'd31, 32'd4, 32'd1, 32'd0}, 4'd7, 1'b1, 4'b0101,
          {32'h8000_0000, 32'hF800_0000, 32'h8000_0000, 32'h8000_0000}, 4'b0000);
    // Scalar sub and slt
    issue(rep(32'd7), rep(32'd7), 4'd1, 1'b0, 4'h0, '0, 4'hF);
    issue({96'h5, 32'hFFFF_FFFF}, {96'h3, 32'h0}, 4'd10, 1'b0, 4'hF,
          {96'h0, 32'h1}, 4'b1110);
    // Further directed vectors, issued back to back
    issue(rep(32'hF0F0_F0F0), rep(32'hFF00_FF00), 4'd4, 1'b1, 4'hF, rep(32'h0FF0_0FF0), 4'h0);
    issue(rep(32'd1), {32'd0, 32'd1, 32'd8, 32'h0000_003F}, 4'd5, 1'b1, 4'hF,
          {32'h1, 32'h2, 32'h100, 32'h8000_0000}, 4'h0);
    issue({32'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000},
          {32'hFFFF_FFFB, 32'd2, 32'h8000_0000, 32'h0}, 4'd8, 1'b1, 4'hF,
          {32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000}, 4'h0);
    issue({32'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000},
          {32'hFFFF_FFFB, 32'd2, 32'h8000_0000, 32'h0}, 4'd9, 1'b1, 4'hF,
          {32'h5, 32'h2, 32'h7FFF_FFFF, 32'h0}, 4'b0001);
    issue(rep(32'h1234_5678), rep(32'h1), 4'd13, 1'b1, 4'b0011,
          {32'h1234_5678, 32'h1234_5678, 64'h0}, 4'b0011);
    issue(rep(32'h8000_0000), rep(32'd4), 4'd6, 1'b1, 4'hF, rep(32'h0800_0000), 4'h0);
    issue(rep(32'hCAFE_0001), rep(32'h1), 4'd3, 1'b1, 4'h0, rep(32'hCAFE_0001), 4'h0);
    issue(rep(32'h0), rep(32'h1), 4'd1, 1'b1, 4'hF, rep(32'hFFFF_FFFF), 4'h0);
    drain();

    // Backpressure: in_valid held, out_ready low for 4 cycles
    out_ready = 1'b0;
    idx = 0;
    cyc = 0;
    first_low = -1;
    while (idx < 5 && cyc < 40) begin
      a = rep(LANE_W'(idx)); b = rep(32'd100); op = 4'd0; vectorial = 1'b1;
      lane_mask = 4'hF; in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (!acc && first_low < 0) first_low = idx;
      @(posedge clk);
      #1;
      if (acc) begin
        e.r = rep(LANE_W'(idx + 100));
        e.z = 4'h0;
        exp_q.push_back(e);
        idx++;
      end
      cyc++;
      if (cyc == 4) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", W'(idx), 5);
    check("bp_ready_fell_after", W'(first_low), 2);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    issue(rep(32'd1), rep(32'd2), 4'd0, 1'b1, 4'hF, rep(32'd3), 4'h0);
    issue(rep(32'd4), rep(32'd5), 4'd0, 1'b1, 4'hF, rep(32'd9), 4'h0);
    check("full_in_ready", W'(in_ready), 0);
    check("full_out_valid", W'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_result", result, 0);
    check("midrst_lane_zero", W'(lane_zero), 0);
    check("midrst_in_ready", W'(in_ready), 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", W'(in_ready), 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_output", W'(stale), 0);
    @(posedge clk);
    #1;

    // Full throughput: 16 random back-to-back ops
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i % 4 == 0) rb = ra;
      ro = 4'($urandom_range(0, 15));
      rv = 1'($urandom_range(0, 1));
      rm = 4'($urandom_range(0, 15));
      e = ref_op(ra, rb, ro, rv, rm);
      issue(ra, rb, ro, rv, rm, e.r, e.z);
    end
    drain();
    check("throughput_run", W'(max_run >= 16), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
